// File: rtl/serial_port_pkg.sv
// serial_port_pkg: shared modes, state type and counter sizing for serial_shift_port
package serial_port_pkg;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchroniser with selectable reset level
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {STAGES{RESET_VAL}};
    else sync_q <= {sync_q[STAGES-2:0], d};
  end
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/serial_shift_port.sv
// serial_shift_port: SPI-style shift port with parallel capture, frame-length check and strobes
module serial_shift_port
  import serial_port_pkg::*;
#(
  parameter int   WIDTH       = 7,
  parameter logic CPOL        = 1'b1,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclk,
  input  logic             ce,
  input  logic             sin,
  input  logic [WIDTH-1:0] par_in,
  output logic             sout,
  output logic [WIDTH-1:0] par_out,
  output logic             done,
  output logic             err
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] SAT  = CW'(WIDTH + 1);
  logic sclk_s, ce_s, sin_s, sclk_p_q, ce_p_q;
  logic lead, trail, sample, shift, ce_fall, ce_rise;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, par_out_q, par_out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sout_r_q, sout_r_d, done_q, done_d, err_q, err_d;
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (.clk(clk), .reset_n(reset_n), .d(sclk), .q(sclk_s));
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ce   (.clk(clk), .reset_n(reset_n), .d(ce),   .q(ce_s));
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sin  (.clk(clk), .reset_n(reset_n), .d(sin),  .q(sin_s));
  assign lead    = (sclk_p_q == CPOL) && (sclk_s != CPOL);
  assign trail   = (sclk_p_q != CPOL) && (sclk_s == CPOL);
  assign sample  = CPHA ? trail : lead;
  assign shift   = CPHA ? lead : trail;
  assign ce_fall = ce_p_q && !ce_s;
  assign ce_rise = !ce_p_q && ce_s;
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    sout_r_d  = sout_r_q;
    par_out_d = par_out_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (state_q == IDLE) begin
      if (ce_fall) begin
        state_d  = ACTIVE;
        shreg_d  = par_in;
        sout_r_d = par_in[WIDTH-1];
        cnt_d    = '0;
      end
    end else begin
      if (sample) begin
        shreg_d = {shreg_q[WIDTH-2:0], sin_s};
        cnt_d   = (cnt_q == SAT) ? cnt_q : cnt_q + CW'(1);
      end
      if (shift) sout_r_d = shreg_q[WIDTH-1];
      // a closing ce edge sees any bit sampled in the same cycle
      if (ce_rise) begin
        state_d   = IDLE;
        done_d    = (cnt_d == FULL);
        err_d     = (cnt_d != FULL);
        par_out_d = (cnt_d == FULL) ? shreg_d : par_out_q;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_p_q  <= 1'b0;
      ce_p_q    <= 1'b1;
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      sout_r_q  <= 1'b0;
      par_out_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sclk_p_q  <= sclk_s;
      ce_p_q    <= ce_s;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      sout_r_q  <= sout_r_d;
      par_out_q <= par_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  assign sout    = sout_r_q && (state_q == ACTIVE);
  assign par_out = par_out_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule

// File: tb/tb_serial_shift_port.sv
// tb_serial_shift_port: mode 2 and mode 3 ports driven from shared pins, checked against a frame-level model
module tb_serial_shift_port;
  localparam int W = 7;
  logic clk = 1'b0, reset_n = 1'b0, sclk = 1'b1, ce = 1'b1, sin = 1'b0;
  logic [W-1:0] par_in = '0;
  logic sout0, sout1, done0, done1, err0, err1;
  logic [W-1:0] po0, po1;
  int pass = 0, total = 0;
  int nd0 = 0, ne0 = 0, nd1 = 0, ne1 = 0;
  logic [W-1:0] exp_po;
  typedef struct {
    logic [W-1:0] pi;
    int           n;
    logic [15:0]  bits;
    logic [W-1:0] po;
    int           d;
    int           e;
  } vec_t;
  vec_t tbl[4];
  always #5 clk = ~clk;
  serial_shift_port #(.WIDTH(W), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .ce(ce), .sin(sin), .par_in(par_in),
    .sout(sout0), .par_out(po0), .done(done0), .err(err0));
  serial_shift_port #(.WIDTH(W), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .ce(ce), .sin(sin), .par_in(par_in),
    .sout(sout1), .par_out(po1), .done(done1), .err(err1));
  always @(posedge clk) begin
    if (done0) nd0++;
    if (err0) ne0++;
    if (done1) nd1++;
    if (err1) ne1++;
  end
  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // bits are sent MSB first: bit i of the frame is bits[n-1-i]
  task automatic frame(input logic [W-1:0] pi, input int n, input logic [15:0] bits, input int d, input int e);
    int d0, e0, d1, e1;
    d0 = nd0; e0 = ne0; d1 = nd1; e1 = ne1;
    par_in = pi;
    ce = 1'b0;
    wt(6);
    for (int i = 0; i < n; i++) begin
      sin = bits[n-1-i];
      wt(6);
      if (i < W) chk("sout_m2", sout0, pi[W-1-i]);
      sclk = 1'b0;
      wt(6);
      if (i < W) chk("sout_m3", sout1, pi[W-1-i]);
      sclk = 1'b1;
      wt(6);
    end
    ce = 1'b1;
    wt(8);
    chk("done_m2", nd0 - d0, d);
    chk("err_m2", ne0 - e0, e);
    chk("done_m3", nd1 - d1, d);
    chk("err_m3", ne1 - e1, e);
    chk("par_out_m2", po0, exp_po);
    chk("par_out_m3", po1, exp_po);
    chk("sout_idle", {sout0, sout1}, 0);
  endtask
  initial begin
    tbl[0] = '{pi: 7'h55, n: 7, bits: 16'b1001011, po: 7'h4B, d: 1, e: 0};
    tbl[1] = '{pi: 7'h2A, n: 5, bits: 16'b10110,   po: 7'h4B, d: 0, e: 1};
    tbl[2] = '{pi: 7'h33, n: 8, bits: 16'hA5,      po: 7'h4B, d: 0, e: 1};
    tbl[3] = '{pi: 7'h7F, n: 7, bits: 16'h12,      po: 7'h12, d: 1, e: 0};
    exp_po = '0;
    wt(3);
    reset_n = 1'b1;
    wt(4);
    chk("reset_par_out", {po0, po1}, 0);
    chk("reset_strobes", {done0, err0, done1, err1}, 0);
    chk("reset_sout", {sout0, sout1}, 0);
    for (int i = 0; i < 20; i++) begin
      sin = i[0];
      sclk = ~sclk;
      wt(6);
    end
    chk("idle_cnt", {dut0.cnt_q, dut1.cnt_q}, 0);
    chk("idle_sout", {sout0, sout1}, 0);
    chk("idle_strobes", nd0 + ne0 + nd1 + ne1, 0);
    for (int i = 0; i < 4; i++) begin
      exp_po = tbl[i].po;
      frame(tbl[i].pi, tbl[i].n, tbl[i].bits, tbl[i].d, tbl[i].e);
    end
    for (int i = 0; i < 12; i++) begin
      int n;
      logic [15:0] b;
      logic [W-1:0] pi;
      n = (i == 0) ? 0 : $urandom_range(9, 0);
      if (i % 3 == 1) n = W;
      b = 16'($urandom);
      pi = W'($urandom);
      if (n == W) exp_po = b[W-1:0];
      frame(pi, n, b, (n == W) ? 1 : 0, (n == W) ? 0 : 1);
    end
    par_in = 7'h5A;
    ce = 1'b0;
    wt(6);
    for (int i = 0; i < 3; i++) begin
      sin = 1'b1;
      wt(6);
      sclk = 1'b0;
      wt(6);
      sclk = 1'b1;
      wt(6);
    end
    reset_n = 1'b0;
    ce = 1'b1;
    wt(2);
    chk("rst_par_out", {po0, po1}, 0);
    chk("rst_sout", {sout0, sout1}, 0);
    chk("rst_strobes", {done0, err0, done1, err1}, 0);
    reset_n = 1'b1;
    wt(8);
    exp_po = 7'h01;
    frame(7'h3C, 7, 16'h01, 1, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/serial_shift_port.md
# serial_shift_port

Parametrised serial-in/serial-out shift-register port with chip enable, parallel capture and parallel readback. It generalises the single-width, single-mode serial cell to any word width and any of the four clock-polarity/phase modes. It adds a synchronous parallel load, frame-length checking and completion/error strobes. It sits between the TinyTapeout `io_in`/`io_out` pins and the user logic: `sclk`, `ce` and `sin` come from pins, and all internal logic runs on `clk`.

## Interface
- `WIDTH`, default 7: shift-register and parallel word width, minimum 2.
- `CPOL`, default 1: idle level of `sclk`.
- `CPHA`, default 0: selects the sample edge.
  - 0: sample on the leading edge.
  - 1: sample on the trailing edge.
- `SYNC_STAGES`, default 2: synchroniser depth for `sclk`, `ce` and `sin`, minimum 2.

Ports:
- `clk` in 1: system clock. All state is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: serial clock pin, asynchronous to `clk`.
- `ce` in 1: chip enable pin, active low.
- `sin` in 1: serial data in, MSB first.
- `par_in` in WIDTH: word shifted out on `sout` during the next frame. Captured at frame start.
- `sout` out 1: serial data out, MSB first. Forced to 0 while the port is deselected.
- `par_out` out WIDTH: last correctly received word.
- `done` out 1: one-`clk` pulse when a frame of exactly WIDTH bits ends.
- `err` out 1: one-`clk` pulse when a frame of any other length ends.

## Operation
- **Synchronisers:** `sclk`, `ce` and `sin` each pass through SYNC_STAGES flops. One further flop per signal holds its previous synchronised value for edge detection.
- **Edge names:**
  - Leading edge: synchronised `sclk` changes from CPOL to !CPOL.
  - Trailing edge: the opposite transition.
  - Sample edge: the leading edge if CPHA=0, else the trailing edge.
  - Shift edge: the other one of the two.
- **States:** IDLE, ACTIVE.
- **IDLE to ACTIVE:** on a synchronised `ce` falling edge. In the same cycle:
  - `shreg` <= `par_in`.
  - `sout_r` <= `par_in[WIDTH-1]`.
  - `cnt` <= 0.
- **In ACTIVE, on a sample edge:**
  - `shreg` <= {`shreg[WIDTH-2:0]`, `sin_sync`}.
  - `cnt` <= `cnt`+1, saturating at WIDTH+1.
- **In ACTIVE, on a shift edge:** `sout_r` <= `shreg[WIDTH-1]`.
- **ACTIVE to IDLE:** on a synchronised `ce` rising edge.
  - If `cnt`==WIDTH: `par_out` <= `shreg` and `done` pulses.
  - Otherwise `par_out` holds and `err` pulses. This covers short frames, over-length frames and zero-bit frames.
- **In IDLE:** `sclk` and `sin` activity is ignored and `shreg` and `cnt` hold.
- **Output gating:** `sout` = `sout_r` AND ACTIVE.
- **Simultaneous events:** a `ce` rising edge in the same cycle as a sample edge is evaluated with that bit already counted and shifted in. A sample edge and a shift edge cannot coincide.
- **Counter width:** `cnt` is $clog2(WIDTH+2) bits.

## Timing
- **Reset values:**
  - State IDLE.
  - `shreg`, `sout_r`, `cnt` and `par_out` all 0.
  - `sout`, `done` and `err` all 0.
  - All synchroniser and edge-detect flops 0, except the `ce` chain, which resets to 1 (deselected).
- **Reset mid-frame:** aborts the frame with no `done`/`err` pulse. After release the port needs a fresh `ce` falling edge.
- **Pin-to-action latency:**
  - A pin transition on `sclk` or `ce` acts at the (SYNC_STAGES+1)th rising `clk` edge after it.
  - `sout` changes SYNC_STAGES+1 `clk` cycles after the shift-edge pin transition.
- **Bit-timing rules:**
  - `sclk` high and low phases must each be at least SYNC_STAGES+2 `clk` periods.
  - `sin` must be stable for SYNC_STAGES+1 `clk` periods before the sample edge.
  - `ce` must be held for SYNC_STAGES+2 `clk` periods before the first `sclk` edge and after the last one.
- **Strobes:** `done` and `err` are registered and exactly one cycle wide. `par_out` is valid in the cycle `done` is high.

## Structure
- Package `serial_port_pkg`:
  - Mode localparams: MODE0={CPOL,CPHA}=00 through MODE3=11.
  - State enum {IDLE, ACTIVE}.
  - Function returning the `cnt` width.
- Sub-module `bit_synchronizer`:
  - Parameter: STAGES.
  - Ports: `clk`, `reset_n`, `d`, `q`.
  - Parameter RESET_VAL, so the `ce` chain resets to 1.
  - Instantiated three times.

## Test plan
- **Mode CPOL=1/CPHA=0, WIDTH=7, `par_in`=7'h55:** shift bits 1,0,0,1,0,1,1, then raise `ce`.
  - `par_out`=7'h4B.
  - `done` pulses once.
  - `sout` carries 1,0,1,0,1,0,1.
- **Short frame:** 5 bits then `ce` high.
  - `err` pulses once.
  - `par_out` stays 7'h4B.
  - No `done`.
- **Over-length frame:** 8 bits.
  - `err` pulses once.
  - `par_out` unchanged.
- **CPOL=1/CPHA=1:** send 7'h12 with `par_in`=7'h7F.
  - `par_out`=7'h12.
  - `sout` is all ones.
  - `done` pulses.
- **`ce` held high, 20 `sclk` toggles:**
  - `cnt` stays 0.
  - `sout`=0.
  - No strobes.
- **`reset_n` low after 3 bits:**
  - All outputs at reset values.
  - A following full 7-bit frame sends 7'h01 and gives `par_out`=7'h01 and `done` once.
